// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared ALU
module alu_arbiter #(
    parameter logic [6:0] LAST_OP = 7'd12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [6:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [6:0]  req1_op,
    output logic [31:0] aluA,
    output logic [31:0] aluB,
    output logic [6:0]  aluOpcode,
    input  logic [31:0] aluOut,
    input  logic        aluCarry,
    input  logic [4:0]  aluFlags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] done_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t      state;
    logic        last_grant;
    logic        grant0;
    logic        grant1;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [6:0]  sel_op;
    logic        unused_carry;

    // Carry already arrives as aluFlags[4]; the separate pin is ignored.
    assign unused_carry = aluCarry;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !reset) begin
            if (req0_valid && !req1_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid && !req0_valid) begin
                grant1 = 1'b1;
            end else if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sel_a      = grant1 ? req1_a  : req0_a;
    assign sel_b      = grant1 ? req1_b  : req0_b;
    assign sel_op     = grant1 ? req1_op : req0_op;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            aluA       <= '0;
            aluB       <= '0;
            aluOpcode  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        last_grant <= grant1;
                        rsp_id     <= grant1;
                        // Illegal opcodes never reach the ALU, so its inputs keep their last values.
                        if (sel_op > LAST_OP) begin
                            rsp_data  <= '0;
                            rsp_flags <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            aluA      <= sel_a;
                            aluB      <= sel_b;
                            aluOpcode <= sel_op;
                            state     <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    rsp_data  <= aluOut;
                    rsp_flags <= aluFlags;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        done_count <= done_count + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed table-driven bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [6:0]  req0_op, req1_op;
    logic [31:0] aluA, aluB, aluOut;
    logic [6:0]  aluOpcode;
    logic        aluCarry;
    logic [4:0]  aluFlags;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic [15:0] done_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_count = 16'd0;
    logic [6:0]  exp_op = 7'd0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .aluA(aluA), .aluB(aluB), .aluOpcode(aluOpcode),
        .aluOut(aluOut), .aluCarry(aluCarry), .aluFlags(aluFlags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy), .done_count(done_count)
    );

    // Shared ALU model: 3 = add, 4 = sub (carry = borrow), others = xor.
    logic [32:0] wide;
    logic        ovf;
    always_comb begin
        wide = 33'd0;
        ovf  = 1'b0;
        case (aluOpcode)
            7'd3: begin
                wide = {1'b0, aluA} + {1'b0, aluB};
                ovf  = (aluA[31] == aluB[31]) && (wide[31] != aluA[31]);
            end
            7'd4: begin
                wide = {1'b0, aluA} - {1'b0, aluB};
                ovf  = (aluA[31] != aluB[31]) && (wide[31] != aluA[31]);
            end
            default: wide = {1'b0, aluA ^ aluB};
        endcase
    end
    assign aluOut   = wide[31:0];
    assign aluCarry = wide[32];
    assign aluFlags = {wide[32], wide[31], wide[31:0] == 32'd0, ^wide[31:0], ovf};

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [6:0]  op0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [6:0]  op1;
        logic        exp_id;
        logic [31:0] exp_data;
        logic [4:0]  exp_flags;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v);
        int lat;
        @(negedge clk);
        rsp_ready  = 1'b0;
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
        #1;
        chk("grant", {req1_ready, req0_ready}, v.exp_id ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'hDEADBEEF; req1_a = 32'hCAFEF00D; req0_op = 7'd4; req1_op = 7'd4;
        lat = 1;
        while (!rsp_valid && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, v.exp_err ? 32'd1 : 32'd2);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, v.exp_id});
        chk("rsp_data", rsp_data, v.exp_data);
        chk("rsp_flags", {27'd0, rsp_flags}, {27'd0, v.exp_flags});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
        if (!v.exp_err) exp_op = v.exp_id ? v.op1 : v.op0;
        chk("aluOpcode", {25'd0, aluOpcode}, {25'd0, exp_op});
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        chk("rsp_valid_clear", {31'd0, rsp_valid}, 32'd0);
        chk("done_count", {16'd0, done_count}, {16'd0, exp_count});
    endtask

    initial begin
        int n;
        int both;
        int bad;
        logic ids[4];
        logic [31:0] snap_data;
        logic [4:0]  snap_flags;
        logic        snap_id;

        vecs[0] = '{1'b1, 1'b0, 32'd5, 32'd7, 7'd3, 32'd0, 32'd0, 7'd0,
                    1'b0, 32'd12, 5'b00000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, 7'd3, 32'h7FFFFFFF, 32'd1, 7'd3,
                    1'b1, 32'h80000000, 5'b01011, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'd3, 32'd5, 7'd4, 32'd9, 32'd9, 7'd0,
                    1'b0, 32'hFFFFFFFE, 5'b11010, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd0, 32'd0, 7'd0, 32'd1, 32'd2, 7'd13,
                    1'b1, 32'd0, 5'b00000, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'hF0, 32'h0F, 7'd12, 32'd1, 32'd1, 7'd127,
                    1'b0, 32'hFF, 5'b00000, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, 7'd3, 32'd1, 32'd1, 7'd127,
                    1'b1, 32'd0, 5'b00000, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 7'd3, 32'd0, 32'd0, 7'd0,
                    1'b0, 32'd0, 5'b10100, 1'b0};

        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd1; req0_b = 32'd1; req0_op = 7'd3;
        req1_a = 32'd1; req1_b = 32'd1; req1_op = 7'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_done_count", {16'd0, done_count}, 32'd0);
        chk("reset_aluA", aluA, 32'd0);
        chk("reset_aluOpcode", {25'd0, aluOpcode}, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        for (int i = 0; i < 7; i++) do_txn(vecs[i]);

        // Round-robin with both requesters held valid from a fresh reset.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0; exp_count = 16'd0; exp_op = 7'd0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 7'd3;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 7'd3;
        rsp_ready = 1'b1;
        n = 0; both = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both++;
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                ids[n] = rsp_id;
                n++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_count", n, 32'd4);
        chk("rr_both_ready", both, 32'd0);
        for (int i = 0; i < 4; i++) chk("rr_order", {31'd0, ids[i]}, (i % 2 == 1) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count = exp_count + 16'd4;
        chk("rr_done_count", {16'd0, done_count}, {16'd0, exp_count});

        // Backpressure: response held for 5 cycles while both requesters wait.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 7'd3;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 6) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_rsp_data", rsp_data, 32'd30);
        snap_data = rsp_data; snap_flags = rsp_flags; snap_id = rsp_id;
        req0_valid = 1'b1; req1_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== snap_data || rsp_flags !== snap_flags ||
                rsp_id !== snap_id || aluA !== 32'd10 || aluB !== 32'd20 ||
                aluOpcode !== 7'd3 || req0_ready || req1_ready) bad++;
        end
        chk("bp_stable", bad, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        chk("bp_idle", {31'd0, busy}, 32'd0);
        chk("bp_done_count", {16'd0, done_count}, {16'd0, exp_count});

        // Reset while in SETTLE.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_op = 7'd3;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("settle_busy", {30'd0, busy, rsp_valid}, 32'd2);
        @(negedge clk);
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("reset_hi_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_settle_busy", {31'd0, busy}, 32'd0);
        chk("rst_settle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_settle_done_count", {16'd0, done_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        exp_count = 16'd0; exp_op = 7'd0;
        vecs[0].v1 = 1'b1; vecs[0].a1 = 32'd8; vecs[0].b1 = 32'd8; vecs[0].op1 = 7'd3;
        do_txn(vecs[0]);

        // Counter wrap from 16'hFFFF.
        @(negedge clk);
        force dut.done_count = 16'hFFFF;
        #1;
        release dut.done_count;
        #1;
        chk("wrap_preload", {16'd0, done_count}, 32'h0000FFFF);
        exp_count = 16'hFFFF;
        do_txn(vecs[3]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
